// File: rtl/coax_pkg.sv
// Shared constants and types for the SPI device front end.
// Byte width, bit-counter width and the idle fill byte sent when control loads nothing.
package coax_pkg;

   localparam int SPI_BYTE_BITS = 8;
   localparam int SPI_CNT_W     = $clog2(SPI_BYTE_BITS);

   typedef logic [SPI_BYTE_BITS-1:0] spi_byte_t;
   typedef logic [SPI_CNT_W-1:0]     spi_cnt_t;

   localparam spi_byte_t SPI_TX_IDLE  = 8'h00;
   localparam spi_cnt_t  SPI_CNT_LAST = spi_cnt_t'(SPI_BYTE_BITS - 1);

endpackage

// File: rtl/synchronizer.sv
// Multi-bit, multi-stage flip-flop synchronizer with a per-bit reset value.
// Each bit is synchronized independently; no cross-bit coherency is implied.
module synchronizer #(
   parameter int               DEPTH     = 2,
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/spi_device.sv
// SPI mode-0 peripheral front end: oversamples the host pins in the clk domain,
// delivers received bytes to control and shifts control's reply byte out on CIPO.
module spi_device
   import coax_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            spi_sck,
   input  logic            spi_cs,
   input  logic            spi_copi,
   output logic            spi_cipo,
   output logic            spi_cipo_oe,
   output logic            cs,
   output spi_byte_t       rx_data,
   output logic            rx_strobe,
   input  spi_byte_t       tx_data,
   input  logic            tx_strobe
);

   // The CS bit resets high so the device starts out deselected.
   logic [2:0] sync_q;
   logic       sck_s;
   logic       cs_s;
   logic       copi_s;

   synchronizer #(
      .DEPTH     (SYNC_STAGES),
      .WIDTH     (3),
      .RESET_VAL (3'b010)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({spi_sck, spi_cs, spi_copi}),
      .q     (sync_q)
   );

   assign sck_s  = sync_q[2];
   assign cs_s   = sync_q[1];
   assign copi_s = sync_q[0];

   logic                       sck_q;
   spi_cnt_t                   bit_cnt,   bit_cnt_n;
   logic [SPI_BYTE_BITS-2:0]   rx_shift,  rx_shift_n;
   spi_byte_t                  rx_data_n;
   logic                       byte_done, byte_done_n;
   spi_byte_t                  tx_hold,   tx_hold_n;
   spi_byte_t                  tx_shift,  tx_shift_n;
   logic                       tx_frozen, tx_frozen_n;
   logic                       cipo_n;

   logic selected;
   logic sck_rise;
   logic sck_fall;

   assign selected = ~cs_s;
   assign sck_rise = selected &  sck_s & ~sck_q;
   assign sck_fall = selected & ~sck_s &  sck_q;

   always_comb begin
      bit_cnt_n   = bit_cnt;
      rx_shift_n  = rx_shift;
      rx_data_n   = rx_data;
      byte_done_n = 1'b0;
      tx_hold_n   = tx_hold;
      tx_shift_n  = tx_shift;
      tx_frozen_n = tx_frozen;

      if (!selected) begin
         bit_cnt_n   = '0;
         rx_shift_n  = '0;
         tx_shift_n  = '0;
         tx_hold_n   = SPI_TX_IDLE;
         tx_frozen_n = 1'b0;
      end else begin
         if (sck_rise) begin
            rx_shift_n = {rx_shift[SPI_BYTE_BITS-3:0], copi_s};
            bit_cnt_n  = bit_cnt + 1'b1;
            if (bit_cnt == SPI_CNT_LAST) begin
               rx_data_n   = {rx_shift, copi_s};
               byte_done_n = 1'b1;
            end
            if (bit_cnt == '0) begin
               tx_shift_n  = tx_hold;
               tx_hold_n   = SPI_TX_IDLE;
               tx_frozen_n = 1'b1;
            end
         end else if (sck_fall && tx_frozen) begin
            // The fall after the last bit releases the holding register for the next byte.
            if (bit_cnt != '0) tx_shift_n = {tx_shift[SPI_BYTE_BITS-2:0], 1'b0};
            else               tx_frozen_n = 1'b0;
         end
         // A load on the first rise lands in tx_hold for the following byte.
         if (tx_strobe) tx_hold_n = tx_data;
      end

      // Between bytes tx_hold is transparent so a late load still reaches the pin.
      cipo_n = 1'b0;
      if (selected) begin
         if (bit_cnt == '0 && !tx_frozen) cipo_n = tx_hold[SPI_BYTE_BITS-1];
         else                             cipo_n = tx_shift[SPI_BYTE_BITS-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q       <= 1'b0;
         bit_cnt     <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         byte_done   <= 1'b0;
         rx_strobe   <= 1'b0;
         tx_hold     <= SPI_TX_IDLE;
         tx_shift    <= '0;
         tx_frozen   <= 1'b0;
         cs          <= 1'b1;
         spi_cipo_oe <= 1'b0;
         spi_cipo    <= 1'b0;
      end else begin
         sck_q       <= sck_s;
         bit_cnt     <= bit_cnt_n;
         rx_shift    <= rx_shift_n;
         rx_data     <= rx_data_n;
         byte_done   <= byte_done_n;
         rx_strobe   <= byte_done;
         tx_hold     <= tx_hold_n;
         tx_shift    <= tx_shift_n;
         tx_frozen   <= tx_frozen_n;
         cs          <= cs_s;
         spi_cipo_oe <= selected;
         spi_cipo    <= cipo_n;
      end
   end

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device: a host model drives SPI mode 0 at clk/16 and a
// scoreboard queue holds the bytes expected on rx_data in arrival order.
module tb_spi_device;

   logic       clk;
   logic       reset;
   logic       spi_sck;
   logic       spi_cs;
   logic       spi_copi;
   logic       spi_cipo;
   logic       spi_cipo_oe;
   logic       cs;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic [7:0] tx_data;
   logic       tx_strobe;

   int checks;
   int errors;
   int cyc;
   int rise8_cyc;
   int strobes;
   int pushed;
   logic [7:0] exp_q [$];

   spi_device #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_sck     (spi_sck),
      .spi_cs      (spi_cs),
      .spi_copi    (spi_copi),
      .spi_cipo    (spi_cipo),
      .spi_cipo_oe (spi_cipo_oe),
      .cs          (cs),
      .rx_data     (rx_data),
      .rx_strobe   (rx_strobe),
      .tx_data     (tx_data),
      .tx_strobe   (tx_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rx(input logic [7:0] b);
      exp_q.push_back(b);
      pushed++;
   endtask

   // Host transfer: data changes with SCK low, CIPO is sampled at the SCK rise.
   task automatic spi_xfer(input logic [7:0] mosi, input int nbits,
                           input logic coll, input logic [7:0] coll_val,
                           output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_copi = mosi[7-i];
         repeat (8) @(negedge clk);
         spi_sck = 1'b1;
         miso = {miso[6:0], spi_cipo};
         if (i == 7) rise8_cyc = cyc;
         if (coll && i == 0) begin
            repeat (2) @(negedge clk);
            tx_data   = coll_val;
            tx_strobe = 1'b1;
            @(negedge clk);
            tx_strobe = 1'b0;
            repeat (5) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic load_tx(input logic [7:0] b);
      tx_data   = b;
      tx_strobe = 1'b1;
      @(negedge clk);
      tx_strobe = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cipo"},    spi_cipo,    1'b0);
      check({tag, "_oe"},      spi_cipo_oe, 1'b0);
      check({tag, "_cs"},      cs,          1'b1);
      check({tag, "_rx_data"}, rx_data,     8'h00);
      check({tag, "_strobe"},  rx_strobe,   1'b0);
   endtask

   // Scoreboard: every strobe must match the oldest pending byte and land 4 cycles after the 8th rise.
   always @(negedge clk) begin
      if (rx_strobe) begin
         strobes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL rx_unexpected observed=%0h expected=no_strobe", rx_data);
         end
         if (exp_q.size() != 0) begin
            check("rx_data", rx_data, exp_q.pop_front());
            check("rx_latency", cyc - rise8_cyc, 4);
         end
      end
   end

   initial begin
      logic [7:0] miso;
      checks = 0; errors = 0; strobes = 0; pushed = 0; rise8_cyc = 0;
      reset = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_copi = 1'b0;
      tx_data = 8'h00; tx_strobe = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("init");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte, then cs lag on select
      spi_cs = 1'b0;
      repeat (2) @(negedge clk);
      check("cs_lag2_sel", cs, 1'b1);
      @(negedge clk);
      check("cs_lag3_sel", cs, 1'b0);
      check("oe_selected", spi_cipo_oe, 1'b1);
      repeat (5) @(negedge clk);
      push_rx(8'hA5);
      spi_xfer(8'hA5, 8, 1'b0, 8'h00, miso);
      check("single_miso_idle", miso, 8'h00);
      repeat (10) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      check("oe_deselected", spi_cipo_oe, 1'b0);

      // Echo: control answers 2 cycles after rx_strobe
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
      fork
         spi_xfer(8'h11, 8, 1'b0, 8'h00, miso);
         begin
            for (int t = 0; t < 400 && !rx_strobe; t++) @(negedge clk);
            check("echo_strobe_seen", rx_strobe, 1'b1);
            repeat (2) @(negedge clk);
            load_tx(8'h3C);
         end
      join
      check("echo_byte1_miso", miso, 8'h00);
      spi_xfer(8'h22, 8, 1'b0, 8'h00, miso);
      check("echo_byte2_miso", miso, 8'h3C);
      spi_xfer(8'h33, 8, 1'b0, 8'h00, miso);
      check("echo_byte3_miso", miso, 8'h00);
      repeat (10) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);

      // Preload before any SCK
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      load_tx(8'h81);
      repeat (4) @(negedge clk);
      push_rx(8'h6E);
      spi_xfer(8'h6E, 8, 1'b0, 8'h00, miso);
      check("preload_miso", miso, 8'h81);
      check("preload_oe", spi_cipo_oe, 1'b1);
      repeat (10) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      check("preload_oe_off", spi_cipo_oe, 1'b0);

      // Abort after 5 bits, then a clean byte
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      spi_xfer(8'hFF, 5, 1'b0, 8'h00, miso);
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (2) @(negedge clk);
      check("cs_lag2_desel", cs, 1'b0);
      @(negedge clk);
      check("cs_lag3_desel", cs, 1'b1);
      repeat (10) @(negedge clk);
      check("abort_no_strobe", strobes, pushed);
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      push_rx(8'h0F);
      spi_xfer(8'h0F, 8, 1'b0, 8'h00, miso);
      repeat (10) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);

      // Collision of tx_strobe with the detected first rise
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      load_tx(8'hAA);
      repeat (4) @(negedge clk);
      push_rx(8'h12); push_rx(8'h34);
      spi_xfer(8'h12, 8, 1'b1, 8'h55, miso);
      check("collide_byte1_miso", miso, 8'hAA);
      spi_xfer(8'h34, 8, 1'b0, 8'h00, miso);
      check("collide_byte2_miso", miso, 8'h55);

      // Reset mid-byte
      spi_xfer(8'hE7, 3, 1'b0, 8'h00, miso);
      check("pre_reset_rx_data", rx_data, 8'h34);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midbyte_reset");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      spi_cs = 1'b0;
      repeat (10) @(negedge clk);
      push_rx(8'hC3);
      spi_xfer(8'hC3, 8, 1'b0, 8'h00, miso);
      repeat (10) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 0);
      check("strobe_count", strobes, pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
